// File: rtl/ddr_ctrl_sched_if.sv
// Handshake bundle between the DDR scheduler and the init sequencer, RW datapath
// and command encoder. The scheduler uses the slave modport.
interface ddr_ctrl_sched_if #(
  parameter int MAX_OWED = 8
);
  localparam int OW = $clog2(MAX_OWED + 1);

  logic          ini_done;
  logic          rw_idle;
  logic          mrs_req;
  logic [2:0]    state;
  logic          busy;
  logic          rw_proc;
  logic          ref_cmd;
  logic          mrs_cmd;
  logic [OW-1:0] ref_owed;
  logic          mrs_pending;

  modport master (
    output ini_done, rw_idle, mrs_req,
    input  state, busy, rw_proc, ref_cmd, mrs_cmd, ref_owed, mrs_pending
  );

  modport slave (
    input  ini_done, rw_idle, mrs_req,
    output state, busy, rw_proc, ref_cmd, mrs_cmd, ref_owed, mrs_pending
  );
endinterface

// File: rtl/ddr_ctrl_sched.sv
// DDR controller scheduling FSM: init, activate, RW, refresh and MRS sequencing.
// Define DDR_REF_POSTPONE_EN to let RW postpone refreshes up to POSTPONE_MAX owed.
module ddr_ctrl_sched #(
  parameter int T_REFI       = 6240,
  parameter int T_RFC        = 280,
  parameter int T_RC         = 39,
  parameter int T_MOD        = 24,
  parameter int MAX_OWED     = 8,
  parameter int POSTPONE_MAX = 4
) (
  input logic             CK_t,
  input logic             reset_n,
  ddr_ctrl_sched_if.slave bus
);
  localparam int REFI_W = $clog2(T_REFI) + 1;
  localparam int RFC_W  = $clog2(T_RFC) + 1;
  localparam int RC_W   = $clog2(T_RC) + 1;
  localparam int MOD_W  = $clog2(T_MOD) + 1;
  localparam int OW     = $clog2(MAX_OWED + 1);

  localparam logic [REFI_W-1:0] REFI_LAST = REFI_W'(T_REFI - 1);
  localparam logic [RFC_W-1:0]  RFC_LAST  = RFC_W'(T_RFC - 1);
  localparam logic [RC_W-1:0]   RC_LAST   = RC_W'(T_RC - 1);
  localparam logic [MOD_W-1:0]  MOD_LAST  = MOD_W'(T_MOD - 1);
  localparam logic [OW-1:0]     OWED_SAT  = OW'(MAX_OWED);

  if (POSTPONE_MAX < 1 || POSTPONE_MAX > MAX_OWED) begin : g_bad_postpone
    $error("ddr_ctrl_sched: POSTPONE_MAX must lie in 1..MAX_OWED");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INIT     = 3'd1,
    ACTIVATE = 3'd2,
    RW       = 3'd3,
    WAIT     = 3'd4,
    REFRESH  = 3'd5,
    UPDATE   = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [REFI_W-1:0]   ref_timer_q, ref_timer_d;
  logic [RFC_W-1:0]    rfc_cnt_q, rfc_cnt_d;
  logic [RC_W-1:0]     row_cnt_q, row_cnt_d;
  logic [MOD_W-1:0]    mod_cnt_q, mod_cnt_d;
  logic [OW-1:0]       ref_owed_q, ref_owed_d;
  logic                mrs_pending_q, mrs_pending_d;
  logic                ref_wrap, win_end, owed_any, rw_exit, ref_chain;

  assign owed_any = (ref_owed_q != '0);
  assign win_end  = (state_q == REFRESH) && (rfc_cnt_q == RFC_LAST);

  // The refresh interval only runs once the device has been initialised.
  always_comb begin
    ref_timer_d = ref_timer_q;
    ref_wrap    = 1'b0;
    if (state_q == IDLE || state_q == INIT) begin
      ref_timer_d = '0;
    end else if (ref_timer_q == REFI_LAST) begin
      ref_timer_d = '0;
      ref_wrap    = 1'b1;
    end else begin
      ref_timer_d = ref_timer_q + REFI_W'(1);
    end
  end

  // A new interval and a completed window in the same cycle cancel out.
  always_comb begin
    ref_owed_d = ref_owed_q;
    if (ref_wrap && !win_end) begin
      if (ref_owed_q != OWED_SAT) ref_owed_d = ref_owed_q + OW'(1);
    end else if (win_end && !ref_wrap && owed_any) begin
      ref_owed_d = ref_owed_q - OW'(1);
    end
  end

`ifdef DDR_REF_POSTPONE_EN
  localparam logic [OW-1:0] POSTPONE_LIM = OW'(POSTPONE_MAX);
  assign rw_exit   = (ref_owed_q >= POSTPONE_LIM) || (owed_any && bus.rw_idle) || mrs_pending_q;
  assign ref_chain = (ref_owed_d != '0);
`else
  assign rw_exit   = owed_any || mrs_pending_q;
  assign ref_chain = 1'b0;
`endif

  // Interval counters clear whenever they are not advancing, so none of them wraps.
  always_comb begin
    state_d   = state_q;
    row_cnt_d = '0;
    rfc_cnt_d = '0;
    mod_cnt_d = '0;
    case (state_q)
      IDLE:     state_d = INIT;
      INIT:     if (bus.ini_done) state_d = ACTIVATE;
      ACTIVATE: begin
        if (owed_any || mrs_pending_q)  state_d = WAIT;
        else if (row_cnt_q == RC_LAST)  state_d = RW;
        else                            row_cnt_d = row_cnt_q + RC_W'(1);
      end
      RW:       if (rw_exit) state_d = WAIT;
      WAIT: begin
        if (bus.rw_idle) begin
          if (owed_any)           state_d = REFRESH;
          else if (mrs_pending_q) state_d = UPDATE;
          else                    state_d = ACTIVATE;
        end
      end
      REFRESH: begin
        if (win_end) begin
          if (!ref_chain) state_d = ACTIVATE;
        end else begin
          rfc_cnt_d = rfc_cnt_q + RFC_W'(1);
        end
      end
      UPDATE: begin
        if (mod_cnt_q == MOD_LAST) state_d = ACTIVATE;
        else                       mod_cnt_d = mod_cnt_q + MOD_W'(1);
      end
      default:  state_d = IDLE;
    endcase
  end

  // A request arriving on the UPDATE entry cycle wins over the clear.
  always_comb begin
    mrs_pending_d = mrs_pending_q;
    if (state_q == WAIT && state_d == UPDATE) mrs_pending_d = 1'b0;
    if (bus.mrs_req && state_q != IDLE && state_q != INIT) mrs_pending_d = 1'b1;
  end

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      ref_timer_q   <= '0;
      rfc_cnt_q     <= '0;
      row_cnt_q     <= '0;
      mod_cnt_q     <= '0;
      ref_owed_q    <= '0;
      mrs_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ref_timer_q   <= ref_timer_d;
      rfc_cnt_q     <= rfc_cnt_d;
      row_cnt_q     <= row_cnt_d;
      mod_cnt_q     <= mod_cnt_d;
      ref_owed_q    <= ref_owed_d;
      mrs_pending_q <= mrs_pending_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.busy        = (state_q == REFRESH) || (state_q == UPDATE);
  assign bus.rw_proc     = (state_q == RW);
  assign bus.ref_cmd     = (state_q == REFRESH) && (rfc_cnt_q == '0);
  assign bus.mrs_cmd     = (state_q == UPDATE) && (mod_cnt_q == '0);
  assign bus.ref_owed    = ref_owed_q;
  assign bus.mrs_pending = mrs_pending_q;
endmodule
